// File: rtl/series_sequencer_pkg.sv
// Shared definitions for the series sequencer: default sizing constants,
// the derived numerator M and the controller state encoding.
package series_sequencer_pkg;

   localparam int unsigned NBITS_V        = 64;
   localparam int unsigned NBITS_A        = 8;
   localparam int unsigned DIVIDEND       = 4;
   localparam int unsigned NUM_DIGITS_HEX = 15;
   localparam int unsigned NDIV           = 16;

   // Divisor a+2i never exceeds 255+30, so 10 bits always suffice.
   localparam int unsigned DIVISOR_W = 10;
   localparam int unsigned TERM_W    = 4;

   // Scaled numerator: DIVIDEND shifted left by one nibble per hex digit.
   localparam logic [NBITS_V-1:0] M =
      NBITS_V'(DIVIDEND) << (DIVIDEND * NUM_DIGITS_HEX);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      DIV  = 3'd2,
      ACC  = 3'd3,
      DONE = 3'd4
   } state_e;

endpackage

// File: rtl/series_sequencer_divider.sv
// serial_divider: restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk_2, reset   - clock, synchronous active-high reset (aborts a divide)
//   start_i        - one-cycle request; dividend_i/divisor_i sampled with it
//   dividend_i     - WIDTH-bit dividend
//   divisor_i      - DW-bit divisor, must be non-zero
//   valid_o        - one-cycle pulse, quotient_o valid; WIDTH cycles after start
//   quotient_o     - WIDTH-bit quotient, held until the next start
module serial_divider #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DW    = 10
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [DW-1:0]    divisor_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] quotient_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [DW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             valid_q, valid_d;

   logic [DW-1:0]    src_rem;
   logic [WIDTH-1:0] src_quo;
   logic [DW:0]      shifted;
   logic             ge;
   logic [DW-1:0]    step_rem;
   logic [WIDTH-1:0] step_quo;

   // One shift-subtract step. The first step happens on the start edge itself,
   // so the last quotient bit lands exactly WIDTH edges after start.
   always_comb begin
      src_rem  = start_i ? '0 : rem_q;
      src_quo  = start_i ? dividend_i : quo_q;
      shifted  = {src_rem, src_quo[WIDTH-1]};
      ge       = (shifted >= {1'b0, divisor_i});
      step_rem = ge ? DW'(shifted - {1'b0, divisor_i}) : shifted[DW-1:0];
      step_quo = {src_quo[WIDTH-2:0], ge};
   end

   // Iteration control.
   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      valid_d = 1'b0;
      if (start_i) begin
         rem_d = step_rem;
         quo_d = step_quo;
         cnt_d = CNT_W'(1);
         run_d = 1'b1;
      end else if (run_q) begin
         rem_d = step_rem;
         quo_d = step_quo;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            run_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         valid_q <= valid_d;
      end
   end

   assign valid_o    = valid_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/series_sequencer.sv
// series_sequencer: accumulates the alternating series
//   v = sum_{i=0}^{NDIV-1} (-1)^i * floor(M / (a + 2i))
// using one shared serial divider, one quotient per term.
// Ports:
//   clk_2  - clock
//   reset  - synchronous active-high reset, wins over start
//   start  - compute request, only honoured in IDLE
//   a      - series base, captured on the accepted start
//   busy   - high in every state except IDLE
//   done   - one-cycle completion pulse, v valid from this cycle
//   v      - result, held until the next run completes
//   term   - index of the term in progress, 0 outside LOAD/DIV/ACC
module series_sequencer #(
   parameter int unsigned NBITS_V        = series_sequencer_pkg::NBITS_V,
   parameter int unsigned NBITS_A        = series_sequencer_pkg::NBITS_A,
   parameter int unsigned DIVIDEND       = series_sequencer_pkg::DIVIDEND,
   parameter int unsigned NUM_DIGITS_HEX = series_sequencer_pkg::NUM_DIGITS_HEX,
   parameter int unsigned NDIV           = series_sequencer_pkg::NDIV
) (
   input  logic               clk_2,
   input  logic               reset,
   input  logic               start,
   input  logic [NBITS_A-1:0] a,
   output logic               busy,
   output logic               done,
   output logic [NBITS_V-1:0] v,
   output logic [3:0]         term
);

   import series_sequencer_pkg::*;

   // One quotient bit per cycle, so a divide takes as many cycles as bits.
   localparam int unsigned DIV_CYCLES = NBITS_V;

   localparam logic [NBITS_V-1:0] NUMER =
      NBITS_V'(DIVIDEND) << (DIVIDEND * NUM_DIGITS_HEX);

   localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NDIV - 1);

   state_e               state_q, state_d;
   logic [NBITS_A-1:0]   a_q, a_d;
   logic [NBITS_V-1:0]   acc_q, acc_d;
   logic [NBITS_V-1:0]   v_q, v_d;
   logic [TERM_W-1:0]    i_q, i_d;
   logic [TERM_W-1:0]    term_q, term_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic                 div_start_c;
   logic [DIVISOR_W-1:0] div_divisor_c;
   logic                 div_valid;
   logic [NBITS_V-1:0]   div_quot;

   assign div_start_c   = (state_q == LOAD);
   assign div_divisor_c = DIVISOR_W'(a_q) + DIVISOR_W'({i_q, 1'b0});

   serial_divider #(
      .WIDTH (DIV_CYCLES),
      .DW    (DIVISOR_W)
   ) u_div (
      .clk_2      (clk_2),
      .reset      (reset),
      .start_i    (div_start_c),
      .dividend_i (NUMER),
      .divisor_i  (div_divisor_c),
      .valid_o    (div_valid),
      .quotient_o (div_quot)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      acc_d   = acc_q;
      v_d     = v_q;
      i_d     = i_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               acc_d   = '0;
               i_d     = '0;
               // a==0 skips every divide, so the divider never sees zero.
               state_d = (a == '0) ? DONE : LOAD;
            end
         end
         LOAD: state_d = DIV;
         DIV: begin
            if (div_valid) state_d = ACC;
         end
         ACC: begin
            // Partial sums of this alternating series stay within [0, M].
            acc_d = i_q[0] ? (acc_q - div_quot) : (acc_q + div_quot);
            if (i_q == LAST_TERM) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + TERM_W'(1);
               state_d = LOAD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they align with it.
      if (state_d == DONE) v_d = acc_d;
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
      term_d = (state_d == LOAD || state_d == DIV || state_d == ACC) ? i_d : '0;
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         acc_q   <= '0;
         v_q     <= '0;
         i_q     <= '0;
         term_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         v_q     <= v_d;
         i_q     <= i_d;
         term_q  <= term_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign v    = v_q;
   assign term = term_q;

endmodule

// File: tb/tb_series_sequencer.sv
// Directed testbench for series_sequencer at default parameters.
module tb_series_sequencer;

   logic        clk_2;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic        busy;
   logic        done;
   logic [63:0] v;
   logic [3:0]  term;

   int total;
   int bad;

   series_sequencer dut (
      .clk_2 (clk_2),
      .reset (reset),
      .start (start),
      .a     (a),
      .busy  (busy),
      .done  (done),
      .v     (v),
      .term  (term)
   );

   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   // Reference: v = sum (-1)^i * floor(2^62 / (a+2i)), i = 0..15.
   function automatic logic [63:0] golden(input int unsigned av);
      logic [63:0] s;
      logic [63:0] q;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         q = 64'h4000_0000_0000_0000 / 64'(av + 2 * i);
         s = (i % 2 == 0) ? (s + q) : (s - q);
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   // Present start for one edge, then count edges until done (bounded).
   task automatic launch(input logic [7:0] av, output int n);
      a     = av;
      start = 1'b1;
      tick();
      start = 1'b0;
      n     = 0;
      while (done !== 1'b1 && n < 1200) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      a     = 8'd1;
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
      total++; if (v !== 64'd0) begin bad++; $display("FAIL reset_v: got %h want 0", v); end
      total++; if (term !== 4'd0) begin bad++; $display("FAIL reset_term: got %0d want 0", term); end
      reset = 1'b0;
      start = 1'b0;
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%0b want 0", busy); end
   endtask

   task automatic test_a1();
      int n;
      launch(8'd1, n);
      total++; if (n !== 1056) begin bad++; $display("FAIL a1_latency: got %0d edges want 1056", n); end
      total++; if (v !== golden(1)) begin bad++; $display("FAIL a1_value: got %h want %h", v, golden(1)); end
      total++; if ((v >> 60) !== 64'd3) begin bad++; $display("FAIL a1_top_bits: got %0d want 3", v >> 60); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL a1_busy_at_done: got %0b want 1", busy); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL a1_done_pulse: got %0b want 0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL a1_idle: got busy=%0b want 0", busy); end
   endtask

   task automatic test_zero();
      int n;
      launch(8'd0, n);
      total++; if (n !== 0) begin bad++; $display("FAIL zero_latency: got %0d edges want 0", n); end
      total++; if (v !== 64'd0) begin bad++; $display("FAIL zero_value: got %h want 0", v); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %0b want 1", busy); end
      total++; if (term !== 4'd0) begin bad++; $display("FAIL zero_term: got %0d want 0", term); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_one_cycle: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %0b want 0", done); end
   endtask

   task automatic test_a255();
      int terr;
      terr  = 0;
      a     = 8'd255;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 1056; n++) begin
         total++;
         if (term !== 4'(n / 66)) begin
            bad++;
            if (terr < 8) $display("FAIL a255_term: edge %0d got %0d want %0d", n, term, n / 66);
            terr++;
         end
         tick();
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL a255_done: got %0b want 1", done); end
      total++; if (v !== golden(255)) begin bad++; $display("FAIL a255_value: got %h want %h", v, golden(255)); end
      total++; if (term !== 4'd0) begin bad++; $display("FAIL a255_term_done: got %0d want 0", term); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      a     = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 498; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
      total++; if (v !== 64'd0) begin bad++; $display("FAIL rmid_v: got %h want 0", v); end
      total++; if (term !== 4'd0) begin bad++; $display("FAIL rmid_term: got %0d want 0", term); end
      pulses = 0;
      for (int k = 0; k < 1200; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_stays_idle: got %0b want 0", busy); end
      launch(8'd1, n);
      total++; if (n !== 1056) begin bad++; $display("FAIL rmid_rerun_latency: got %0d want 1056", n); end
      total++; if (v !== golden(1)) begin bad++; $display("FAIL rmid_rerun_value: got %h want %h", v, golden(1)); end
      tick();
   endtask

   task automatic test_ignore_start();
      int pulses;
      int done_at;
      logic [63:0] v_at_done;
      pulses    = 0;
      done_at   = -1;
      v_at_done = '0;
      a         = 8'd5;
      start     = 1'b1;
      tick();
      for (int n = 1; n <= 1100; n++) begin
         start = (n == 10 || n == 600);
         a     = (n >= 600) ? 8'd9 : ((n >= 10) ? 8'd200 : 8'd5);
         tick();
         if (done === 1'b1) begin
            pulses++;
            done_at   = n;
            v_at_done = v;
         end
      end
      start = 1'b0;
      total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
      total++; if (done_at !== 1056) begin bad++; $display("FAIL ign_latency: got %0d want 1056", done_at); end
      total++; if (v_at_done !== golden(5)) begin bad++; $display("FAIL ign_value: got %h want %h", v_at_done, golden(5)); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int at [3];
      int verr;
      logic [63:0] exp_v;
      pulses = 0;
      verr   = 0;
      exp_v  = golden(5);
      at[0] = -1; at[1] = -1; at[2] = -1;
      a      = 8'd3;
      start  = 1'b1;
      tick();
      for (int n = 1; n <= 3300 && pulses < 3; n++) begin
         tick();
         if (done === 1'b1) begin
            at[pulses] = n;
            pulses++;
            exp_v = golden(3);
         end
         total++;
         if (v !== exp_v) begin
            bad++;
            if (verr < 8) $display("FAIL b2b_v_stable: edge %0d got %h want %h", n, v, exp_v);
            verr++;
         end
      end
      start = 1'b0;
      total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
      total++; if (at[0] !== 1056) begin bad++; $display("FAIL b2b_first: got %0d want 1056", at[0]); end
      total++; if (at[1] - at[0] !== 1058) begin bad++; $display("FAIL b2b_period1: got %0d want 1058", at[1] - at[0]); end
      total++; if (at[2] - at[1] !== 1058) begin bad++; $display("FAIL b2b_period2: got %0d want 1058", at[2] - at[1]); end
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: got busy=%0b want 0", busy); end
      total++; if (v !== golden(3)) begin bad++; $display("FAIL b2b_hold: got %h want %h", v, golden(3)); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      a     = 8'd0;
      test_reset();
      test_a1();
      test_zero();
      test_a255();
      test_reset_mid();
      test_ignore_start();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/series_sequencer.md
SERIES_SEQUENCER -- requirements
Module: series_sequencer

Interface
REQ-001 Parameter NBITS_V, default 64, width of the accumulated result.
REQ-002 Parameter NBITS_A, default 8, width of the series base operand.
REQ-003 Parameter DIVIDEND, default 4, numerator scale factor.
REQ-004 Parameter NUM_DIGITS_HEX, default 15, fractional hex digits.
REQ-005 Parameter NDIV, default 16, number of terms; legal values are even, 2..16.
REQ-006 Parameter DIV_CYCLES, fixed at NBITS_V, cycles per divide.
REQ-007 Port clk_2, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 Port reset, input, 1 bit, synchronous active-high reset.
REQ-009 Port start, input, 1 bit, request to compute; sampled only in IDLE.
REQ-010 Port a, input, NBITS_A bits, series base; captured on the accepted start.
REQ-011 Port busy, output, 1 bit, high in every state except IDLE.
REQ-012 Port done, output, 1 bit, single-cycle completion pulse.
REQ-013 Port v, output, NBITS_V bits, result register; held until the next accepted start completes.
REQ-014 Port term, output, 4 bits, index i of the term in progress (for LCD display).

Function
REQ-015 The block SHALL compute v = sum over i=0..NDIV-1 of (-1)^i * floor(M/(a+2i)), where M = DIVIDEND << (DIVIDEND*NUM_DIGITS_HEX) (2^62 at defaults).
REQ-016 The block SHALL perform all divisions on one shared serial divider, one quotient per term.
REQ-017 FSM states SHALL be IDLE, LOAD, DIV, ACC, DONE.
REQ-018 IDLE with start=1: capture a, clear acc and i; go to DONE if a==0, else go to LOAD.
REQ-019 LOAD: issue a one-cycle divider start with divisor a+2i (10-bit, zero-extended); go to DIV.
REQ-020 DIV: wait for divider valid, which arrives exactly DIV_CYCLES cycles after the LOAD cycle; then go to ACC.
REQ-021 ACC: acc += q when i is even and acc -= q when i is odd; if i==NDIV-1 go to DONE, else increment i and go to LOAD.
REQ-022 DONE: v <= acc, done=1 for this one cycle only; go to IDLE.
REQ-023 Latency from start sampled at edge k, a!=0: done is high in cycle k+1+NDIV*(DIV_CYCLES+2), which is k+1057 at defaults.
REQ-024 Latency from start sampled at edge k, a==0: done is high in cycle k+1 with v=0; no division is performed.
REQ-025 Arithmetic SHALL be unsigned; partial sums are non-negative and at most M, so no overflow or sign handling is required.
REQ-026 A start asserted while busy SHALL be ignored, and a input changes while busy SHALL have no effect.
REQ-027 start held high continuously SHALL begin a new computation on the IDLE cycle following DONE.
REQ-028 term SHALL equal i during LOAD, DIV and ACC, and SHALL be 0 otherwise.

Reset
REQ-029 On reset=1 at a rising edge the block SHALL enter IDLE with v=0, acc=0, i=0, done=0 and busy=0.
REQ-030 Reset mid-operation SHALL abort the divider, so that no stale valid pulse is consumed afterwards.
REQ-031 Reset SHALL take priority over start in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, LOAD, DIV, ACC, DONE), the default constants NBITS_V, NBITS_A, DIVIDEND, NUM_DIGITS_HEX and NDIV, and the derived constant M.
REQ-033 The sub-module serial_divider SHALL be a restoring divider with one quotient bit per cycle.
REQ-034 serial_divider SHALL have a 64-bit dividend, a 10-bit divisor, start/valid handshake ports, and clk_2/reset inputs.
REQ-035 Divide by zero SHALL NOT reach serial_divider; the a==0 bypass guarantees this.

Verification
REQ-036 Start with a=0 -> done in cycle k+1, v=0, busy high for exactly one cycle.
REQ-037 Start with a=1, defaults -> done at k+1057; v matches the golden model; v>>60 == 3 (4-scaled Leibniz partial sum, approx. 3.079).
REQ-038 Start with a=255 -> v matches the golden model exactly; term steps through 0..15 once per 66 cycles.
REQ-039 Reset asserted at cycle k+500 during a=1 run -> next cycle: IDLE, v=0, done never pulses; a new start then gives the correct result.
REQ-040 start pulsed at k+10 and k+600 during a run, with a changed -> both ignored; result equals the original a; done pulses once.
REQ-041 start held high with a=3 -> back-to-back runs; done pulses every 1058 cycles; v is stable between pulses.
